// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, controller states and
// small helpers for alignment, byte-lane enables and store-data replication.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [3:0] byteEnables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating narrow stores across all lanes lets the bus pick any lane by byte enable.
  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane extraction of bus read data followed by sign/zero extension.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rData,
  input  logic [1:0]  byteOff,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic [31:0] loadData
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = rData[{byteOff, 3'b000} +: 8];
    laneHalf = byteOff[1] ? rData[31:16] : rData[15:0];
    case (memSize)
      SZ_BYTE: loadData = {{24{memSign & laneByte[7]}}, laneByte};
      SZ_HALF: loadData = {{16{memSign & laneHalf[15]}}, laneHalf};
      default: loadData = rData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage controller: runs one data-memory bus transaction per load/store,
// stalls the pipeline meanwhile and drives the MEM/WB register.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSign,
  input  logic        RegWrite_i,
  input  logic [31:0] Result_i,
  input  logic [31:0] rData2_i,
  input  logic [4:0]  wAddr_i,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_wAddr,
  output logic [31:0] wb_Data,
  output logic        mem_err,
  output mem_state_t  dbgState
);

  // Bus handshake: dm_req rises with dm_we/addr/wdata/be stable and stays high
  // until the edge that samples dm_ack=1 (or the wait budget runs out); the
  // request is completed in that same cycle, with dm_rdata valid alongside dm_ack.

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  mem_state_t  state, nextState;
  logic [7:0]  waitCnt;
  logic [31:0] loadData, alignedData;
  logic        timedOut;
  logic        isMem, isLoad, misaligned, startBus, accept;

  assign isMem      = MemRead | MemWrite;
  assign isLoad     = MemRead;
  assign misaligned = isMisaligned(MemSize, Result_i[1:0]);
  assign startBus   = isMem && !misaligned;
  assign accept     = !stall;
  assign dbgState   = state;

  load_align u_load_align (
    .rData    (dm_rdata),
    .byteOff  (Result_i[1:0]),
    .memSize  (MemSize),
    .memSign  (MemSign),
    .loadData (alignedData)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (startBus) nextState = ST_BUSY;
      ST_BUSY: if (dm_ack || waitCnt == WAIT_LAST) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      ST_IDLE: stall = startBus;
      ST_BUSY: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt     <= '0;
      timedOut    <= 1'b0;
      loadData    <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      dm_be       <= '0;
      wb_RegWrite <= 1'b0;
      wb_wAddr    <= '0;
      wb_Data     <= '0;
      mem_err     <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (startBus) begin
            dm_req   <= 1'b1;
            dm_we    <= !isLoad;
            dm_addr  <= {Result_i[31:2], 2'b00};
            dm_wdata <= storeData(MemSize, rData2_i);
            dm_be    <= byteEnables(MemSize, Result_i[1:0]);
            waitCnt  <= '0;
            timedOut <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            dm_req   <= 1'b0;
            loadData <= alignedData;
          end else if (waitCnt == WAIT_LAST) begin
            dm_req   <= 1'b0;
            mem_err  <= 1'b1;
            timedOut <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: ;
      endcase

      if (accept) begin
        wb_wAddr <= wAddr_i;
        if (state == ST_DONE) begin
          wb_RegWrite <= isLoad && RegWrite_i && !timedOut;
          wb_Data     <= isLoad ? loadData : Result_i;
        end else if (isMem) begin
          // Only a misaligned access is accepted straight from IDLE.
          wb_RegWrite <= 1'b0;
          wb_Data     <= Result_i;
          mem_err     <= 1'b1;
        end else begin
          wb_RegWrite <= RegWrite_i;
          wb_Data     <= Result_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, loads/stores of each
// size, misalignment, bus timeout, ack-vs-timeout race and reset mid-transaction.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, MemSign, RegWrite_i;
  logic [1:0]  MemSize;
  logic [31:0] Result_i, rData2_i;
  logic [4:0]  wAddr_i;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_RegWrite, mem_err;
  logic [4:0]  wb_wAddr;
  logic [31:0] wb_Data;
  mem_state_t  dbgState;

  int nTests = 0;
  int nFail  = 0;

  int          reqCycles;
  logic        obsWe, errDone, stallIdle, stallBusy, stallDone;
  logic [3:0]  obsBe;
  logic [31:0] obsAddr, obsWdata;

  mem_access_unit #(.MAX_WAIT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemSize     (MemSize),
    .MemSign     (MemSign),
    .RegWrite_i  (RegWrite_i),
    .Result_i    (Result_i),
    .rData2_i    (rData2_i),
    .wAddr_i     (wAddr_i),
    .stall       (stall),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_be       (dm_be),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .wb_RegWrite (wb_RegWrite),
    .wb_wAddr    (wb_wAddr),
    .wb_Data     (wb_Data),
    .mem_err     (mem_err),
    .dbgState    (dbgState)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setNop();
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemSize    = 2'b10;
    MemSign    = 1'b0;
    RegWrite_i = 1'b0;
    Result_i   = '0;
    rData2_i   = '0;
    wAddr_i    = '0;
    dm_ack     = 1'b0;
    dm_rdata   = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one aligned memory op; ackAt is the BUSY cycle index that sees dm_ack (-1: never).
  // Returns just after the accept edge out of DONE.
  task automatic memOp(input logic rd, input logic wr, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int ackAt);
    MemRead    = rd;
    MemWrite   = wr;
    MemSize    = size;
    MemSign    = sign;
    RegWrite_i = 1'b1;
    Result_i   = addr;
    rData2_i   = wdata;
    wAddr_i    = 5'd10;
    dm_ack     = 1'b0;
    #1 stallIdle = stall;
    cyc();
    stallBusy = stall;
    obsAddr   = dm_addr;
    obsBe     = dm_be;
    obsWe     = dm_we;
    obsWdata  = dm_wdata;
    reqCycles = 0;
    while (dm_req && reqCycles < 300) begin
      if (reqCycles == ackAt) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end
      cyc();
      dm_ack = 1'b0;
      reqCycles++;
    end
    errDone   = mem_err;
    stallDone = stall;
    cyc();
  endtask

  initial begin
    setNop();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_wb_rw", 32'(wb_RegWrite), 32'd0);
    chk("rst_wb_data", wb_Data, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_state", 32'(dbgState), 32'(ST_IDLE));
    rst = 1'b0;

    // ALU op passes through in one cycle
    RegWrite_i = 1'b1;
    Result_i   = 32'h1234_5678;
    wAddr_i    = 5'd5;
    #1 chk("alu_stall", 32'(stall), 32'd0);
    cyc();
    chk("alu_wb_data", wb_Data, 32'h1234_5678);
    chk("alu_wb_rw", 32'(wb_RegWrite), 32'd1);
    chk("alu_wb_addr", 32'(wb_wAddr), 32'd5);
    setNop();

    // lw 0x100, ack in first BUSY cycle
    memOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_stall_idle", 32'(stallIdle), 32'd1);
    chk("lw_stall_busy", 32'(stallBusy), 32'd1);
    chk("lw_stall_done", 32'(stallDone), 32'd0);
    chk("lw_req_cycles", 32'(reqCycles), 32'd1);
    chk("lw_addr", obsAddr, 32'h0000_0100);
    chk("lw_be", 32'(obsBe), 32'hF);
    chk("lw_we", 32'(obsWe), 32'd0);
    chk("lw_wb_data", wb_Data, 32'hDEAD_BEEF);
    chk("lw_wb_rw", 32'(wb_RegWrite), 32'd1);
    chk("lw_wb_addr", 32'(wb_wAddr), 32'd10);
    chk("lw_state", 32'(dbgState), 32'(ST_IDLE));
    setNop();

    // lb 0x103 signed / unsigned, ack after 2 wait cycles
    memOp(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 2);
    chk("lb_be", 32'(obsBe), 32'h8);
    chk("lb_addr", obsAddr, 32'h0000_0100);
    chk("lb_req_cycles", 32'(reqCycles), 32'd3);
    chk("lbs_wb_data", wb_Data, 32'hFFFF_FF80);
    setNop();
    memOp(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
    chk("lbu_wb_data", wb_Data, 32'h0000_0080);
    setNop();

    // lh 0x102 signed: upper half selected
    memOp(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_1234, 1);
    chk("lh_be", 32'(obsBe), 32'hC);
    chk("lh_wb_data", wb_Data, 32'hFFFF_8001);
    setNop();

    // sh 0x102
    memOp(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1);
    chk("sh_we", 32'(obsWe), 32'd1);
    chk("sh_be", 32'(obsBe), 32'hC);
    chk("sh_wdata", obsWdata, 32'hABCD_ABCD);
    chk("sh_wb_rw", 32'(wb_RegWrite), 32'd0);
    setNop();

    // sb 0x101
    memOp(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_565A, 32'h0, 0);
    chk("sb_be", 32'(obsBe), 32'h2);
    chk("sb_wdata", obsWdata, 32'h5A5A_5A5A);
    setNop();

    // lw 0x101 misaligned: no bus access, one mem_err pulse
    MemRead    = 1'b1;
    MemSize    = 2'b10;
    RegWrite_i = 1'b1;
    Result_i   = 32'h0000_0101;
    wAddr_i    = 5'd4;
    #1 chk("mis_stall", 32'(stall), 32'd0);
    cyc();
    chk("mis_dm_req", 32'(dm_req), 32'd0);
    chk("mis_mem_err", 32'(mem_err), 32'd1);
    chk("mis_wb_rw", 32'(wb_RegWrite), 32'd0);
    setNop();
    cyc();
    chk("mis_err_once", 32'(mem_err), 32'd0);
    chk("mis_dm_req2", 32'(dm_req), 32'd0);

    // Load with wb enabled, then a timeout with no ack
    memOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222, 0);
    chk("pre_to_wb_rw", 32'(wb_RegWrite), 32'd1);
    setNop();
    memOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h0, -1);
    chk("to_req_cycles", 32'(reqCycles), 32'd16);
    chk("to_mem_err", 32'(errDone), 32'd1);
    chk("to_wb_rw", 32'(wb_RegWrite), 32'd0);
    chk("to_err_once", 32'(mem_err), 32'd0);
    setNop();

    // Ack in the last permitted cycle beats the timeout
    memOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 15);
    chk("race_req_cycles", 32'(reqCycles), 32'd16);
    chk("race_mem_err", 32'(errDone), 32'd0);
    chk("race_wb_data", wb_Data, 32'h0BAD_F00D);
    chk("race_wb_rw", 32'(wb_RegWrite), 32'd1);
    setNop();

    // Reset in the third BUSY cycle
    MemRead    = 1'b1;
    MemSize    = 2'b10;
    RegWrite_i = 1'b1;
    Result_i   = 32'h0000_0400;
    wAddr_i    = 5'd7;
    cyc();
    cyc();
    cyc();
    chk("rb_req_before", 32'(dm_req), 32'd1);
    rst = 1'b1;
    cyc();
    chk("rb_dm_req", 32'(dm_req), 32'd0);
    chk("rb_dm_be", 32'(dm_be), 32'd0);
    chk("rb_wb_data", wb_Data, 32'd0);
    chk("rb_wb_rw", 32'(wb_RegWrite), 32'd0);
    chk("rb_state", 32'(dbgState), 32'(ST_IDLE));
    rst = 1'b0;
    setNop();
    RegWrite_i = 1'b1;
    Result_i   = 32'hCAFE_0001;
    wAddr_i    = 5'd9;
    #1 chk("rb_alu_stall", 32'(stall), 32'd0);
    cyc();
    chk("rb_alu_wb_data", wb_Data, 32'hCAFE_0001);
    chk("rb_alu_wb_addr", 32'(wb_wAddr), 32'd9);
    chk("rb_no_err", 32'(mem_err), 32'd0);
    setNop();
    cyc();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MAX_WAIT, default 16: BUSY cycles without dm_ack before a transaction aborts; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 MemRead  in  1  load request from EX/MEM register.
REQ-005 MemWrite  in  1  store request; MemRead and MemWrite both high is treated as load.
REQ-006 MemSize  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 MemSign  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 RegWrite_i  in  1  write-back enable of the current op.
REQ-009 Result_i  in  32  ALU result or effective address.
REQ-010 rData2_i  in  32  store data.
REQ-011 wAddr_i  in  5  destination register.
REQ-012 stall  out  1  holds EX/MEM and earlier stages while high (combinational from state and inputs).
REQ-013 dm_req  out  1  registered bus request; held until the cycle dm_ack is sampled.
REQ-014 dm_we  out  1  registered bus write strobe; valid while dm_req is high.
REQ-015 dm_addr  out  32  registered word address {Result_i[31:2],2'b00}.
REQ-016 dm_wdata  out  32  registered store data, lane-replicated.
REQ-017 dm_be  out  4  registered byte enables; bit n enables bits 8n+7:8n.
REQ-018 dm_ack  in  1  bus completion; dm_rdata is valid in the same cycle.
REQ-019 dm_rdata  in  32  bus read data.
REQ-020 wb_RegWrite, wb_wAddr[4:0], wb_Data[31:0]  out  MEM/WB register outputs.
REQ-021 mem_err  out  1  registered one-cycle pulse: misaligned access or timeout.

Function
REQ-022 FSM states: IDLE, BUSY, DONE.
REQ-023 Accept edge is any rising edge with stall=0. On it, load wb_* from the current op; hold wb_* on all other edges.
REQ-024 Non-memory op in IDLE: stall=0; at the accept edge wb_Data<=Result_i, wb_RegWrite<=RegWrite_i, wb_wAddr<=wAddr_i. Latency is 1 cycle.
REQ-025 Alignment: half requires Result_i[0]=0; word requires Result_i[1:0]=0.
REQ-026 Misaligned memory op in IDLE: no bus access, stall=0, wb_RegWrite<=0, mem_err pulses on the next cycle.
REQ-027 Aligned memory op in IDLE: stall=1; next edge sets dm_req=1, loads dm_* and enters BUSY with the wait counter at 0.
REQ-028 BUSY: stall=1; each cycle without ack increments the counter.
REQ-029 BUSY with dm_ack=1: dm_req<=0, capture the formatted load into an internal register, enter DONE.
REQ-030 BUSY with counter=MAX_WAIT-1 and no ack: dm_req<=0, pulse mem_err, enter DONE with wb_RegWrite forced to 0 for this op.
REQ-031 Ack and timeout in the same cycle: ack wins.
REQ-032 DONE: stall=0; the accept edge loads wb_* (loads: captured data; stores: wb_RegWrite<=0); next state is IDLE.
REQ-033 Minimum memory-op occupancy is 3 cycles (IDLE, BUSY, DONE).
REQ-034 Byte enables: byte 4'b0001<<addr[1:0]; half addr[1] ? 1100 : 0011; word 1111.
REQ-035 Store data: byte {4{rData2_i[7:0]}}; half {2{rData2_i[15:0]}}; word unchanged.
REQ-036 Loads are little-endian: select the addressed byte or half of dm_rdata, then extend per MemSign to 32 bits.
REQ-037 dm_ack outside BUSY is ignored; dm_* registers hold when dm_req=0.

Reset
REQ-038 rst=1 at an edge: state IDLE, counter 0, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_be=0, wb_RegWrite=0, wb_wAddr=0, wb_Data=0, mem_err=0.
REQ-039 Reset during BUSY drops dm_req at that edge; the transaction is abandoned and no wb update or mem_err follows.

Structure
REQ-040 MemSize codes and FSM state encodings are defined in the shared package mips_mem_pkg.
REQ-041 Lane extraction and sign/zero extension are implemented in a combinational sub-module load_align.

Verification
REQ-042 Scenario: lw at 0x100, dm_ack in the first BUSY cycle, dm_rdata=0xDEADBEEF -> stall high for 2 cycles, wb_Data=0xDEADBEEF after DONE.
REQ-043 Scenario: lb at 0x103 with MemSign=1, dm_rdata=0x80123456 -> dm_be=1000, wb_Data=0xFFFFFF80; same with MemSign=0 -> 0x00000080.
REQ-044 Scenario: sh at 0x102 with rData2_i=0x0000ABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, wb_RegWrite=0.
REQ-045 Scenario: lw at 0x101 -> no dm_req, stall never asserted, mem_err pulses once, wb_RegWrite=0.
REQ-046 Scenario: no ack, MAX_WAIT=16 -> dm_req high for exactly 16 cycles, then mem_err pulse; ack and timeout in the same cycle -> data written back, no mem_err.
REQ-047 Scenario: rst asserted in the 3rd BUSY cycle -> dm_req=0 at the next cycle, all outputs at reset values, following ALU op passes through in 1 cycle.
